// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared definitions for the two-requester adder arbiter.
//   ADD_W     - operand / sum width of the shared adder
//   TAG_REQ0  - result tag for requester 0
//   TAG_REQ1  - result tag for requester 1
//   res_t     - one buffered result (tag, carry, sum)
package adder_arbiter_pkg;

  localparam int   ADD_W    = 6;
  localparam logic TAG_REQ0 = 1'b0;
  localparam logic TAG_REQ1 = 1'b1;

  typedef struct packed {
    logic             tag;
    logic             carry;
    logic [ADD_W-1:0] sum;
  } res_t;

endpackage

// File: rtl/six_bit_adder.sv
// six_bit_adder: plain 6-bit ripple-carry adder.
//   x, y  : operands
//   cin   : carry in
//   sum   : (x+y+cin)[5:0]
//   cout  : (x+y+cin)[6]
module six_bit_adder (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);

  logic [6:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 6; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[6];

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin share of one six_bit_adder between two
// requesters, with a one-entry registered result buffer (valid/ready).
//   clk, reset          : clock, async active-high reset
//   req0/a0/b0, gnt0    : requester 0 handshake + operands
//   req1/a1/b1, gnt1    : requester 1 handshake + operands
//   res_valid/res_ready : result buffer handshake
//   res_sum/res_carry   : registered sum of the granted operands
//   res_tag             : which requester issued the buffered result
//   ops_count           : results accepted by the consumer (wraps)
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [ADD_W-1:0] a0,
  input  logic [ADD_W-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [ADD_W-1:0] a1,
  input  logic [ADD_W-1:0] b1,
  output logic             gnt1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ADD_W-1:0] res_sum,
  output logic             res_carry,
  output logic             res_tag,
  output logic [CNT_W-1:0] ops_count
);

  // Buffer state is just the valid flop: 0 = EMPTY, 1 = FULL.
  logic             res_valid_q, res_valid_d;
  res_t             res_q, res_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic             can_accept, gnt_any, gnt_idx, drain;
  logic [ADD_W-1:0] opx, opy, add_sum;
  logic             add_cout;

  // Pass-through: a new op may load in the same cycle the old one drains.
  assign can_accept = !res_valid_q || res_ready;
  assign drain      = res_valid_q && res_ready;

  // Grants are forced low during reset so nothing looks transferred.
  assign gnt0 = !reset && can_accept && req0 && (!req1 || (rr_ptr_q == TAG_REQ0));
  assign gnt1 = !reset && can_accept && req1 && (!req0 || (rr_ptr_q == TAG_REQ1));

  assign gnt_any = gnt0 || gnt1;
  assign gnt_idx = gnt1 ? TAG_REQ1 : TAG_REQ0;

  // Shared datapath operand mux.
  assign opx = gnt1 ? a1 : a0;
  assign opy = gnt1 ? b1 : b0;

  six_bit_adder u_add (
    .x    (opx),
    .y    (opy),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      rr_ptr_q    <= TAG_REQ0;
      ops_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_q       <= ops_d;
    end
  end

  // Next-state logic.
  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    rr_ptr_d    = rr_ptr_q;
    ops_d       = ops_q;
    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_d.sum   = add_sum;
      res_d.carry = add_cout;
      res_d.tag   = gnt_idx;
      // Pointer only moves on a real grant, toward the other requester.
      rr_ptr_d    = ~gnt_idx;
    end else if (drain) begin
      res_valid_d = 1'b0;
    end
    if (drain) ops_d = ops_q + 1'b1;
  end

  // Outputs.
  always_comb begin
    res_valid = res_valid_q;
    res_sum   = res_q.sum;
    res_carry = res_q.carry;
    res_tag   = res_q.tag;
    ops_count = ops_q;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  logic       clk = 1'b0;
  logic       reset, req0, req1, res_ready;
  logic [5:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, res_valid, res_carry, res_tag;
  logic [5:0] res_sum;
  logic [7:0] ops_count;
  logic       gnt0_2, gnt1_2, res_valid_2, res_carry_2, res_tag_2;
  logic [5:0] res_sum_2;
  logic [1:0] ops_count_2;

  always #5 clk = ~clk;

  adder_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_tag(res_tag), .ops_count(ops_count)
  );

  // Narrow-counter instance sharing stimulus, for the wrap check.
  adder_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0_2),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1_2),
    .res_valid(res_valid_2), .res_ready(res_ready), .res_sum(res_sum_2),
    .res_carry(res_carry_2), .res_tag(res_tag_2), .ops_count(ops_count_2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       tag;
    logic [6:0] sum;
  } exp_t;

  exp_t q[$];
  logic m_valid, m_rr, g0, g1;
  int   m_cnt;

  task automatic model_clear();
    q.delete();
    m_valid = 1'b0;
    m_rr    = 1'b0;
    m_cnt   = 0;
    g0      = 1'b0;
    g1      = 1'b0;
  endtask

  // One clock: check at negedge against the model, advance model, pass edge.
  task automatic step();
    logic can;
    exp_t e, f;
    @(negedge clk);
    can = !m_valid || res_ready;
    g0  = can && req0 && (!req1 || !m_rr);
    g1  = can && req1 && (!req0 || m_rr);
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("gnt0_w2", gnt0_2, g0);
    chk("gnt1_w2", gnt1_2, g1);
    chk("res_valid", res_valid, m_valid);
    chk("res_valid_w2", res_valid_2, m_valid);
    if (m_valid && q.size() > 0) begin
      f = q[0];
      chk("res_sum", res_sum, f.sum[5:0]);
      chk("res_carry", res_carry, f.sum[6]);
      chk("res_tag", res_tag, f.tag);
      chk("res_sum_w2", res_sum_2, f.sum[5:0]);
    end
    chk("ops_count", ops_count, m_cnt % 256);
    chk("ops_count_w2", ops_count_2, m_cnt % 4);
    if (m_valid && res_ready) begin
      void'(q.pop_front());
      m_cnt++;
      m_valid = 1'b0;
    end
    if (g0 || g1) begin
      e.tag = g1;
      e.sum = g1 ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
      q.push_back(e);
      m_valid = 1'b1;
      m_rr    = ~g1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req0 = 0; req1 = 0; res_ready = 1;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_clear();
    #3;
    chk("rst_valid", res_valid, 0);
    chk("rst_ops", ops_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Single requester: 5 + 9.
    req0 = 1; a0 = 6'd5; b0 = 6'd9;
    step();
    req0 = 0;
    step(); step();

    // Overflow on requester 1: 63 + 63.
    req1 = 1; a1 = 6'd63; b1 = 6'd63;
    step();
    req1 = 0;
    step(); step();

    // Contention: expect strict alternation.
    req0 = 1; a0 = 6'd10; b0 = 6'd20;
    req1 = 1; a1 = 6'd33; b1 = 6'd40;
    for (int i = 0; i < 4; i++) step();
    req0 = 0; req1 = 0;
    step(); step();

    // Backpressure then pass-through.
    res_ready = 0;
    req0 = 1; a0 = 6'd7; b0 = 6'd8;
    step();
    req0 = 0;
    req1 = 1; a1 = 6'd1; b1 = 6'd2;
    for (int i = 0; i < 3; i++) step();
    res_ready = 1;
    step();
    req1 = 0;
    step(); step();

    // Random traffic; requesters hold until granted.
    for (int i = 0; i < 40; i++) begin
      if (!req0 || g0) begin
        req0 = 1'($urandom); a0 = 6'($urandom); b0 = 6'($urandom);
      end
      if (!req1 || g1) begin
        req1 = 1'($urandom); a1 = 6'($urandom); b1 = 6'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset mid-cycle with a result pending.
    req1 = 0; res_ready = 0;
    req0 = 1; a0 = 6'd3; b0 = 6'd4;
    step();
    chk("pending_before_rst", res_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", res_valid, 0);
    chk("rst_mid_sum", res_sum, 0);
    chk("rst_mid_carry", res_carry, 0);
    chk("rst_mid_tag", res_tag, 0);
    chk("rst_mid_ops", ops_count, 0);
    chk("rst_mid_ops_w2", ops_count_2, 0);
    chk("rst_mid_gnt0", gnt0, 0);
    chk("rst_mid_gnt1", gnt1, 0);
    model_clear();
    #1;
    reset = 1'b0;
    req0 = 0; res_ready = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
